uart_fw_loader: RTL
===================

Name: uart_fw_loader

Overview:
- Serial firmware loader that sits directly upstream of the PicoRV32 SoC wrapper.
- Receives a framed image on a UART pin and writes it word-by-word through the SoC's progmem write port (progmem_wen/waddr/wdata).
- Holds the CPU in reset while a load is in progress and releases it on success or on boot timeout.
- Lets the board be reflashed without a rebuild.

Parameters:
- CLK_HZ, 27000000, system clock frequency.
- BAUD, 115200, UART bit rate. DIV = CLK_HZ/BAUD (integer division), and DIV must be >= 4.
- BASE_ADDR, 32'h0010_0000, byte address of word 0 (the CPU reset vector).
- MAX_WORDS, 4096, largest accepted word count.
- BOOT_WAIT_CYC, 27000000, idle cycles after reset before the CPU is released without a load.
- TIMEOUT_CYC, 2700000, inter-byte timeout. Used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input; idles high; asynchronous to clk.
- progmem_wen  out  1  one-cycle write strobe to progmem.
- progmem_waddr  out  32  byte address of the word being written.
- progmem_wdata  out  32  word being written.
- cpu_resetn  out  1  active-low reset to the SoC.
- load_busy  out  1  high while a frame is being received.
- load_err  out  1  sticky error flag.

Behaviour:
- Reset is synchronous and active-high; all state is clocked on clk.
- Reset values: progmem_wen=0, progmem_waddr=BASE_ADDR, progmem_wdata=0, cpu_resetn=0, load_busy=0, load_err=0, FSM=WAIT_BOOT.
- Reset asserted mid-load returns to the reset state. Words already written are left in progmem.
- RX input: uart_rx passes through a 2-FF synchronizer, reset value 1.
- RX start bit: a falling edge arms the start check. The line is re-sampled at DIV/2 cycles; if it is high, the event is treated as a glitch and the receiver returns to idle.
- RX data: 8 data bits are sampled LSB-first, every DIV cycles at mid-bit. The stop bit is then sampled.
  - Stop bit = 1: byte_valid pulses for one cycle after the stop sample.
  - Stop bit = 0: frame_err pulses instead.
- Frame format, in order: sync byte 0xA5, LEN_LO, LEN_HI (16-bit word count N), N*4 data bytes (each word little-endian), SUM.
- SUM = 8-bit sum mod 256 of the data bytes only.
- WAIT_BOOT: counts cycles.
  - Count reaches BOOT_WAIT_CYC → RUN, and cpu_resetn=1.
  - 0xA5 received → LEN0.
  - Any other byte, or a frame_err, is ignored.
- RUN: cpu_resetn=1.
  - 0xA5 received → LEN0, with cpu_resetn=0 from the next edge.
  - Other bytes and frame_err are ignored.
- LEN0 / LEN1: capture the length bytes; load_busy=1, load_err cleared on entry to LEN0.
  - After LEN1, if N > MAX_WORDS → ERR.
  - After LEN1, if N == 0 → SUM.
  - Otherwise → DATA, with word index k=0 and running sum=0.
- DATA: shifts bytes into the word and adds each to the sum.
  - On the 4th byte of each word: progmem_wen=1 for exactly one cycle, on the edge after that byte's byte_valid. progmem_waddr = BASE_ADDR + 4*k (32-bit wrap), progmem_wdata = assembled word; then k increments.
  - When k == N → SUM.
- SUM: compares the received byte with the running sum.
  - Equal → RUN: cpu_resetn=1, load_busy=0.
  - Not equal → ERR.
- Any frame_err in LEN0, LEN1, DATA or SUM → ERR.
- ERR: load_err=1, load_busy=0, cpu_resetn=0.
  - Only 0xA5 leaves ERR, going to LEN0 and clearing load_err.
- Simultaneous events: byte_valid and an expiring boot counter in the same cycle → the byte wins. If it is 0xA5, the FSM goes to LEN0 and cpu_resetn stays 0.
- progmem_wen is never asserted outside DATA.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: an inter-byte counter runs in LEN0, LEN1, DATA and SUM. It is cleared on every byte_valid. Reaching TIMEOUT_CYC → ERR.
- Not defined: the counter is not built, and the loader waits in these states indefinitely.

Test Plan:
- Boot timeout. Setup: DIV=10, BOOT_WAIT_CYC=1000, uart_rx idle. Required: cpu_resetn rises exactly 1000 cycles after rst deasserts; no progmem_wen.
- Good load. Stimulus: A5 02 00 78 56 34 12 EF BE AD DE 4C. Required:
  - a wen pulse with addr 0x0010_0000, data 0x1234_5678;
  - a wen pulse with addr 0x0010_0004, data 0xDEAD_BEEF;
  - after SUM: cpu_resetn=1, load_busy=0, load_err=0.
- Bad checksum. Stimulus: the same frame ending in 4D. Required: two wen pulses, then load_err=1 and cpu_resetn held 0. A following good frame clears load_err and releases the CPU.
- Oversize length. Setup: MAX_WORDS=4096. Stimulus: A5 01 10 (N=0x1001). Required: ERR right after LEN_HI; zero wen pulses.
- RX robustness.
  - 3-cycle low glitch in WAIT_BOOT → no byte is received.
  - Stop bit forced 0 on the 2nd data byte → ERR, no wen.
  - rst pulsed mid-DATA → all outputs return to reset values.
- With LOADER_TIMEOUT_EN, TIMEOUT_CYC=500. Stimulus: A5 01 00 78, then line idle. Required: load_err=1 500 cycles after the last byte_valid. Without the macro, the FSM stays in DATA.

Source files
------------

// File: rtl/uart_fw_loader.sv
// rtl/uart_fw_loader.sv - UART firmware loader that writes a framed image into PicoRV32 progmem
//
// Receives a frame on uart_rx in this order:
//   A5, LEN_LO, LEN_HI, N*4 data bytes (little-endian words), SUM
// Each assembled word is written to BASE_ADDR + 4*k. The CPU is held in
// reset while a load is in progress. It is released after a good checksum,
// or after BOOT_WAIT_CYC idle cycles following reset.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   uart_rx        serial input, idles high, asynchronous to clk
//   progmem_wen    one-cycle progmem write strobe
//   progmem_waddr  byte address of the word being written
//   progmem_wdata  word being written
//   cpu_resetn     active-low reset to the SoC
//   load_busy      high while a frame is being received
//   load_err       sticky error flag, cleared by the next sync byte
//
// Optional build macro:
//   LOADER_TIMEOUT_EN  adds an inter-byte timeout of TIMEOUT_CYC cycles
//                      that applies while a frame is being received.

module uart_fw_loader #(
  parameter int unsigned CLK_HZ        = 27000000,
  parameter int unsigned BAUD          = 115200,
  parameter logic [31:0] BASE_ADDR     = 32'h0010_0000,
  parameter int unsigned MAX_WORDS     = 4096,
  parameter int unsigned BOOT_WAIT_CYC = 27000000,
  parameter int unsigned TIMEOUT_CYC   = 2700000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        progmem_wen,
  output logic [31:0] progmem_waddr,
  output logic [31:0] progmem_wdata,
  output logic        cpu_resetn,
  output logic        load_busy,
  output logic        load_err
);

  localparam int unsigned DIV     = CLK_HZ / BAUD;
  localparam logic [31:0] DIV_M1  = 32'(DIV - 1);
  localparam logic [31:0] HALF_M1 = 32'((DIV / 2) - 1);
  localparam logic [31:0] BOOT_M1 = 32'(BOOT_WAIT_CYC - 1);
  localparam logic [7:0]  SYNC    = 8'hA5;

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [31:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sr;
  logic        byte_valid;
  logic        frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sr      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Re-check the start bit at its middle; a high line means a glitch.
          if (rx_cnt == HALF_M1) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt <= '0;
            rx_sr  <= {rx_s2, rx_sr[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) byte_valid <= 1'b1;
            else       frame_err  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Frame parser / loader FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_WAIT_BOOT, S_RUN, S_LEN0, S_LEN1, S_DATA, S_SUM, S_ERR
  } state_t;

  state_t      state;
  logic [31:0] boot_cnt;
  logic [7:0]  len_lo;
  logic [15:0] len_n;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_sr;
  logic [7:0]  sum;
  logic        is_sync;
  logic [15:0] len_new;
  logic        in_load;

  assign is_sync = byte_valid && (rx_sr == SYNC);
  assign len_new = {rx_sr, len_lo};
  assign in_load = (state == S_LEN0) || (state == S_LEN1) ||
                   (state == S_DATA) || (state == S_SUM);

`ifdef LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_M1 = 32'(TIMEOUT_CYC - 1);
  logic [31:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_WAIT_BOOT;
      progmem_wen   <= 1'b0;
      progmem_waddr <= BASE_ADDR;
      progmem_wdata <= '0;
      cpu_resetn    <= 1'b0;
      load_busy     <= 1'b0;
      load_err      <= 1'b0;
      boot_cnt      <= '0;
      len_lo        <= '0;
      len_n         <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      word_sr       <= '0;
      sum           <= '0;
`ifdef LOADER_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      progmem_wen <= 1'b0;

      case (state)
        S_WAIT_BOOT: begin
          // A sync byte beats an expiring boot counter in the same cycle.
          if (is_sync) begin
            state      <= S_LEN0;
            cpu_resetn <= 1'b0;
            load_busy  <= 1'b1;
            load_err   <= 1'b0;
          end else if (boot_cnt == BOOT_M1) begin
            state      <= S_RUN;
            cpu_resetn <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 32'd1;
          end
        end
        S_RUN, S_ERR: begin
          if (is_sync) begin
            state      <= S_LEN0;
            cpu_resetn <= 1'b0;
            load_busy  <= 1'b1;
            load_err   <= 1'b0;
          end
        end
        S_LEN0: begin
          if (frame_err) begin
            state      <= S_ERR;
            load_err   <= 1'b1;
            load_busy  <= 1'b0;
            cpu_resetn <= 1'b0;
          end else if (byte_valid) begin
            len_lo <= rx_sr;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (frame_err) begin
            state      <= S_ERR;
            load_err   <= 1'b1;
            load_busy  <= 1'b0;
            cpu_resetn <= 1'b0;
          end else if (byte_valid) begin
            len_n    <= len_new;
            word_idx <= '0;
            byte_idx <= '0;
            sum      <= '0;
            if ({16'd0, len_new} > MAX_WORDS) begin
              state      <= S_ERR;
              load_err   <= 1'b1;
              load_busy  <= 1'b0;
              cpu_resetn <= 1'b0;
            end else if (len_new == 16'd0) begin
              state <= S_SUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (frame_err) begin
            state      <= S_ERR;
            load_err   <= 1'b1;
            load_busy  <= 1'b0;
            cpu_resetn <= 1'b0;
          end else if (byte_valid) begin
            sum      <= sum + rx_sr;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Fourth byte completes the little-endian word.
              progmem_wen   <= 1'b1;
              progmem_waddr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              progmem_wdata <= {rx_sr, word_sr};
              word_idx      <= word_idx + 16'd1;
              if (word_idx + 16'd1 == len_n) state <= S_SUM;
            end else begin
              word_sr <= {rx_sr, word_sr[23:8]};
            end
          end
        end
        S_SUM: begin
          if (frame_err) begin
            state      <= S_ERR;
            load_err   <= 1'b1;
            load_busy  <= 1'b0;
            cpu_resetn <= 1'b0;
          end else if (byte_valid) begin
            if (rx_sr == sum) begin
              state      <= S_RUN;
              cpu_resetn <= 1'b1;
              load_busy  <= 1'b0;
            end else begin
              state      <= S_ERR;
              load_err   <= 1'b1;
              load_busy  <= 1'b0;
              cpu_resetn <= 1'b0;
            end
          end
        end
        default: state <= S_WAIT_BOOT;
      endcase

`ifdef LOADER_TIMEOUT_EN
      // Placed after the case so an expiry overrides the idle-wait branches.
      if (!in_load || byte_valid) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_M1) begin
        to_cnt     <= '0;
        state      <= S_ERR;
        load_err   <= 1'b1;
        load_busy  <= 1'b0;
        cpu_resetn <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end
`else
      if (in_load && byte_valid && frame_err) state <= S_ERR;
`endif
    end
  end

endmodule
